// File: rtl/dm_stack_unit.sv
// Data memory with an internally owned, downward-growing hardware stack.
// One operation per cycle (push > pop > store > load), registered read port,
// sticky stack bounds flags and a request-conflict pulse.
module dm_stack_unit #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned STACK_BASE  = 2**ADDR_W - 1,
  parameter int unsigned STACK_LIMIT = 2**ADDR_W - 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              store,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_err,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W:0]   stack_depth,
  output logic              stack_overflow,
  output logic              stack_underflow,
  output logic              op_conflict
);

  localparam int unsigned     DEPTH   = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] EMPTY_SP = ADDR_W'(STACK_BASE);
  localparam logic [ADDR_W-1:0] FULL_SP  = ADDR_W'(STACK_LIMIT - 1);
  localparam logic [ADDR_W:0]   BASE_EXT = (ADDR_W+1)'(STACK_BASE);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              is_full;
  logic              is_empty;
  logic              do_push;
  logic              do_pop;
  logic              do_store;
  logic              do_load;
  logic              wr_en;
  logic              rd_en;
  logic              ovf_event;
  logic              unf_event;
  logic              conflict;
  logic [2:0]        req_count;
  logic [ADDR_W-1:0] sp_inc;
  logic [ADDR_W-1:0] sp_dec;
  logic [ADDR_W-1:0] sp_next;
  logic [ADDR_W-1:0] mem_addr;

  // Request arbitration, stack bounds and the single memory port address
  always_comb begin
    is_full   = 1'b0;
    is_empty  = 1'b0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    do_store  = 1'b0;
    do_load   = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    ovf_event = 1'b0;
    unf_event = 1'b0;
    sp_inc    = sp + ADDR_W'(1);
    sp_dec    = sp - ADDR_W'(1);
    sp_next   = sp;
    mem_addr  = address;
    req_count = 3'(push) + 3'(pop) + 3'(store) + 3'(load);
    conflict  = (req_count > 3'd1);

    is_full  = (sp == FULL_SP);
    is_empty = (sp == EMPTY_SP);

    do_push  = push;
    do_pop   = pop & ~push;
    do_store = store & ~push & ~pop;
    do_load  = load & ~push & ~pop & ~store;

    if (do_push) begin
      mem_addr = sp;
      if (is_full) begin
        ovf_event = 1'b1;
      end else begin
        wr_en   = 1'b1;
        sp_next = sp_dec;
      end
    end else if (do_pop) begin
      // pre-increment: the top entry sits one slot above the free pointer
      mem_addr = sp_inc;
      if (is_empty) begin
        unf_event = 1'b1;
      end else begin
        rd_en   = 1'b1;
        sp_next = sp_inc;
      end
    end else if (do_store) begin
      wr_en = 1'b1;
    end else if (do_load) begin
      rd_en = 1'b1;
    end
  end

  // Memory write port; an edge coinciding with reset never writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (rst_n && wr_en) begin
      mem[mem_addr] <= wdata;
    end
  end

  // Stack pointer, read register, sticky flags and conflict pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp              <= EMPTY_SP;
      rdata           <= '0;
      rvalid          <= 1'b0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
      op_conflict     <= 1'b0;
    end else begin
      sp     <= sp_next;
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= mem[mem_addr];
      end
      // a new error event wins over a simultaneous clear
      stack_overflow  <= ovf_event | (stack_overflow & ~clr_err);
      stack_underflow <= unf_event | (stack_underflow & ~clr_err);
      op_conflict     <= conflict;
    end
  end

  // Depth follows directly from the pointer
  assign stack_depth = BASE_EXT - {1'b0, sp};

endmodule

// File: doc/dm_stack_unit.md
Name: dm_stack_unit

Overview:
- Parametrised data memory with a built-in hardware stack for the 16-bit processor datapath.
- Serves load/store at an explicit address and push/pop against an internally owned stack pointer.
- Adds a registered read port, stack bounds checking (sticky overflow/underflow), a command-conflict flag and a depth count.
- Sits between the execute stage result bus and the writeback mux.

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 9, address width; memory holds 2**ADDR_W words.
- STACK_BASE, 2**ADDR_W-1, address of the first stack slot; the stack grows downward.
- STACK_LIMIT, 2**ADDR_W-64, lowest address the stack may occupy. Legal range: 1 <= STACK_LIMIT <= STACK_BASE.

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  read mem[address].
- store  input  1  write wdata to mem[address].
- push  input  1  write wdata to mem[sp], then decrement sp.
- pop  input  1  increment sp, then read the top entry.
- clr_err  input  1  clears the sticky error flags.
- address  input  ADDR_W  load/store address.
- wdata  input  DATA_W  write data (ALU result).
- rdata  output  DATA_W  registered read data.
- rvalid  output  1  rdata updated this cycle.
- sp  output  ADDR_W  stack pointer; points to the next free slot.
- stack_depth  output  ADDR_W+1  number of entries, equal to STACK_BASE - sp.
- stack_overflow  output  1  sticky: a push was attempted while full.
- stack_underflow  output  1  sticky: a pop was attempted while empty.
- op_conflict  output  1  one-cycle pulse when more than one of push/pop/store/load is high.

Behaviour:
- Reset (async assert, synchronous release at the next edge): sp=STACK_BASE, rdata=0, rvalid=0, stack_overflow=0, stack_underflow=0, op_conflict=0. Memory contents are not reset. An operation in flight when reset asserts is discarded: no write, no sp change.
- Empty: sp==STACK_BASE. Full: sp==STACK_LIMIT-1. Capacity = STACK_BASE-STACK_LIMIT+1.
- One operation per cycle. Priority is push > pop > store > load; lower-priority requests are dropped. When two or more are high, op_conflict=1 for that next cycle.
- Push, not full: mem[sp]<=wdata; sp<=sp-1; rvalid=0.
- Push, full: no write; sp unchanged; stack_overflow<=1.
- Pop, not empty: sp<=sp+1; rdata<=mem[sp+1]; rvalid=1 next cycle (latency 1).
- Pop, empty: sp unchanged; rdata holds; rvalid=0; stack_underflow<=1.
- Store: mem[address]<=wdata; rvalid=0. Stores into the stack region are permitted and unchecked.
- Load: rdata<=mem[address]; rvalid=1 next cycle.
- No operation: rvalid=0; rdata holds its last value.
- Read-after-write: a load/pop in cycle N+1 of data written in cycle N returns the new data. Only one operation per cycle, so there is no same-cycle collision.
- Error flags stay set until clr_err=1 (clear at the next edge) or reset. If an error event and clr_err occur in the same cycle, the flag is set (set wins).
- sp never leaves [STACK_LIMIT-1, STACK_BASE]; no wrap-around is possible.
- stack_depth is combinational from sp.
- Memory is synchronous-write, synchronous-read, single-port inferable: one access per cycle.

Test Plan:
- Reset/idle: hold rst_n=0, then release -> sp=511, stack_depth=0, rdata=0, rvalid=0, all flags 0. Assert rst_n=0 mid-push -> sp returns to 511 immediately.
- Store/load: store 0xBEEF @0x010, next cycle load @0x010 -> following cycle rdata=0xBEEF, rvalid=1. One idle cycle after -> rvalid=0, rdata=0xBEEF.
- LIFO order: push 0x1111, 0x2222, 0x3333 -> sp=508, depth=3. Three pops -> rdata 0x3333, 0x2222, 0x1111 on consecutive cycles; sp=511.
- Overflow (STACK_LIMIT=508, capacity 4): push 5 values -> 5th not written, sp=507, stack_overflow=1 and stays 1. Pulse clr_err -> flag 0. Pop -> returns the 4th value.
- Underflow: pop on empty -> stack_underflow=1, rvalid=0, sp=511. Same-cycle pop-on-empty with clr_err=1 -> flag remains 1.
- Conflict: push=1 and load=1 with wdata=0x00AA -> push executes (mem[511]=0x00AA, sp=510), no rvalid, op_conflict=1 for one cycle.
